// File: rtl/pipelined_hybrid_adder_pkg.sv
// Shared defaults, mode encoding and stage-count helper for the pipelined hybrid adder.
package pipelined_hybrid_adder_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_BLOCK = 4;
   localparam int DEF_BPS   = 2;

   localparam logic ADD_OP = 1'b0;
   localparam logic SUB_OP = 1'b1;

   function automatic int calc_nstg(input int width, input int block, input int bps);
      return width / (block * bps);
   endfunction

endpackage

// File: rtl/cla_block.sv
// BLOCK-bit combinational carry-look-ahead slice; also exports the carry into its MSB.
module cla_block #(
   parameter int BLOCK = 4
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             ci,
   output logic [BLOCK-1:0] s,
   output logic             co,
   output logic             c_msb
);

   logic [BLOCK-1:0] g;
   logic [BLOCK-1:0] p;
   logic [BLOCK:0]   c;

   // Each carry is the flattened sum-of-products of generates and propagates below it.
   always_comb begin
      logic t;
      logic pp;
      t  = 1'b0;
      pp = 1'b0;
      g  = a & b;
      p  = a ^ b;
      c  = '0;
      c[0] = ci;
      for (int i = 0; i < BLOCK; i++) begin
         t  = g[i];
         pp = p[i];
         for (int j = i - 1; j >= 0; j--) begin
            t  = t | (pp & g[j]);
            pp = pp & p[j];
         end
         c[i+1] = t | (pp & ci);
      end
      s     = p ^ c[BLOCK-1:0];
      co    = c[BLOCK];
      c_msb = c[BLOCK-1];
   end

endmodule

// File: rtl/pipelined_hybrid_adder.sv
// Pipelined add/subtract unit: CLA slices rippled within a stage, one register stage per BPS slices,
// valid/ready flow control with per-stage advance so bubbles are squeezed out under backpressure.
module pipelined_hybrid_adder
   import pipelined_hybrid_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int BLOCK = DEF_BLOCK,
   parameter int BPS   = DEF_BPS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cy_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cy_out,
   output logic             zero,
   output logic             ovf
);

   localparam int S    = BLOCK * BPS;
   localparam int NSTG = calc_nstg(WIDTH, BLOCK, BPS);
   localparam int NREG = (NSTG > 1) ? NSTG - 1 : 1;

   if (WIDTH % S != 0) begin : g_bad_cfg
      $fatal(1, "pipelined_hybrid_adder: WIDTH must be a multiple of BLOCK*BPS");
   end

   logic [NSTG:0]    adv;
   logic [NSTG-1:0]  vld_p;
   logic [WIDTH-1:0] x_q [NREG];
   logic [WIDTH-1:0] y_q [NREG];
   logic             c_q [NREG];
   logic [WIDTH-1:0] beff;
   logic             cin;
   logic             cm_last;

   assign beff = b ^ {WIDTH{sub == SUB_OP}};
   assign cin  = cy_in ^ (sub == SUB_OP);

   always_comb begin
      adv       = '0;
      adv[NSTG] = out_ready;
      for (int k = NSTG - 1; k >= 0; k--) begin
         adv[k] = !vld_p[k] || adv[k+1];
      end
   end

   assign in_ready  = adv[0];
   assign out_valid = vld_p[NSTG-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p <= '0;
      end else begin
         if (adv[0]) vld_p[0] <= in_valid;
         for (int k = 1; k < NSTG; k++) begin
            if (adv[k]) vld_p[k] <= vld_p[k-1];
         end
      end
   end

   // x words hold finished sum bits below the stage boundary and untouched A bits above it;
   // y words hold the not-yet-consumed B bits shifted down so the next slice is always at bit 0.
   for (genvar k = 0; k < NSTG; k++) begin : g_stg
      logic [WIDTH-1:0] xin;
      logic [WIDTH-1:0] x_nx;
      logic [S-1:0]     yop;
      logic [S-1:0]     ssum;
      logic             cin_k;
      logic             vin;
      logic             co_k;

      if (k == 0) begin : g_src0
         assign xin   = a;
         assign yop   = beff[S-1:0];
         assign cin_k = cin;
         assign vin   = in_valid;
      end else begin : g_srck
         assign xin   = x_q[k-1];
         assign yop   = y_q[k-1][S-1:0];
         assign cin_k = c_q[k-1];
         assign vin   = vld_p[k-1];
      end

      for (genvar j = 0; j < BPS; j++) begin : g_blk
         logic ci;
         logic co;
         if (j == 0) begin : g_ci0
            assign ci = cin_k;
         end else begin : g_cij
            assign ci = g_blk[j-1].co;
         end
         if (k == NSTG - 1 && j == BPS - 1) begin : g_msb
            cla_block #(.BLOCK(BLOCK)) u_cla (
               .a     (xin[k*S + j*BLOCK +: BLOCK]),
               .b     (yop[j*BLOCK +: BLOCK]),
               .ci    (ci),
               .s     (ssum[j*BLOCK +: BLOCK]),
               .co    (co),
               .c_msb (cm_last)
            );
         end else begin : g_mid
            logic cm_unused;
            cla_block #(.BLOCK(BLOCK)) u_cla (
               .a     (xin[k*S + j*BLOCK +: BLOCK]),
               .b     (yop[j*BLOCK +: BLOCK]),
               .ci    (ci),
               .s     (ssum[j*BLOCK +: BLOCK]),
               .co    (co),
               .c_msb (cm_unused)
            );
         end
      end

      assign co_k = g_blk[BPS-1].co;

      always_comb begin
         x_nx            = xin;
         x_nx[k*S +: S]  = ssum;
      end

      if (k < NSTG - 1) begin : g_reg
         logic [WIDTH-1:0] ysrc;
         if (k == 0) begin : g_y0
            assign ysrc = beff;
         end else begin : g_yk
            assign ysrc = y_q[k-1];
         end
         // ---- stage k -> k+1 boundary ----
         always_ff @(posedge clk) begin
            if (adv[k] && vin) begin
               x_q[k] <= x_nx;
               y_q[k] <= ysrc >> S;
               c_q[k] <= co_k;
            end
         end
      end else begin : g_out
         // ---- result register ----
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               sum    <= '0;
               cy_out <= 1'b0;
               zero   <= 1'b0;
               ovf    <= 1'b0;
            end else if (adv[k] && vin) begin
               sum    <= x_nx;
               cy_out <= co_k;
               zero   <= (x_nx == '0);
               ovf    <= cm_last ^ co_k;
            end
         end
      end
   end

endmodule

// File: tb/tb_pipelined_hybrid_adder.sv
// Scoreboard bench for pipelined_hybrid_adder: 32-bit default instance plus an 8-bit, BPS=1 instance.
module tb_pipelined_hybrid_adder;
   import pipelined_hybrid_adder_pkg::*;

   typedef struct packed {
      logic [31:0] sum;
      logic        cy;
      logic        zero;
      logic        ovf;
   } res_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        in_valid, in_ready, cy_in, sub, out_valid, out_ready, cy_out, zero, ovf;
   logic [31:0] a, b, sum;

   logic       v2, r2, cy2, sub2, ov2, or2, co2, z2, f2;
   logic [7:0] a2, b2, s2;

   pipelined_hybrid_adder dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .cy_in(cy_in), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cy_out(cy_out), .zero(zero), .ovf(ovf)
   );

   pipelined_hybrid_adder #(.WIDTH(8), .BLOCK(4), .BPS(1)) dut8 (
      .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .a(a2), .b(b2),
      .cy_in(cy2), .sub(sub2), .out_valid(ov2), .out_ready(or2),
      .sum(s2), .cy_out(co2), .zero(z2), .ovf(f2)
   );

   res_t q[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic res_t model(input logic [31:0] ai, input logic [31:0] bi,
                                  input logic ci, input logic si);
      logic [31:0] be;
      logic        c;
      logic [32:0] full;
      res_t        r;
      be     = si ? ~bi : bi;
      c      = si ? ~ci : ci;
      full   = {1'b0, ai} + {1'b0, be} + {32'd0, c};
      r.sum  = full[31:0];
      r.cy   = full[32];
      r.zero = (full[31:0] == 32'd0);
      r.ovf  = (ai[31] == be[31]) && (full[31] != ai[31]);
      return r;
   endfunction

   function automatic res_t observed();
      return res_t'({sum, cy_out, zero, ovf});
   endfunction

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cy_in = 1'b0; sub = ADD_OP;
      v2 = 1'b0; or2 = 1'b1; a2 = '0; b2 = '0; cy2 = 1'b0; sub2 = ADD_OP;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++;
      if (observed() !== res_t'(0)) begin failures++; $display("FAIL reset_outputs got=%h exp=%h", observed(), res_t'(0)); end
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++;
      if ({ov2, s2, co2, z2, f2} !== 12'd0) begin failures++; $display("FAIL reset_dut8 got=%h exp=0", {ov2, s2, co2, z2, f2}); end
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_carry_wrap();
      int   lat;
      res_t exp;
      exp = '{sum: 32'h0000_0000, cy: 1'b1, zero: 1'b1, ovf: 1'b0};
      a = 32'hFFFF_FFFF; b = 32'h0000_0001; cy_in = 1'b0; sub = ADD_OP; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      checks++;
      if (lat !== 4) begin failures++; $display("FAIL wrap_latency got=%0d exp=4", lat); end
      checks++;
      if (observed() !== exp) begin failures++; $display("FAIL wrap_result got=%h exp=%h", observed(), exp); end
      @(posedge clk); #1;
   endtask

   task automatic test_sub_ovf();
      int   lat;
      res_t exp;
      exp = '{sum: 32'h8000_0000, cy: 1'b0, zero: 1'b0, ovf: 1'b1};
      a = 32'h7FFF_FFFF; b = 32'hFFFF_FFFF; cy_in = 1'b0; sub = SUB_OP; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      checks++;
      if (lat !== 4) begin failures++; $display("FAIL subovf_latency got=%0d exp=4", lat); end
      checks++;
      if (observed() !== exp) begin failures++; $display("FAIL subovf_result got=%h exp=%h", observed(), exp); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int   sent, got;
      bit   started;
      res_t exp;
      q.delete(); sent = 0; got = 0; started = 0; out_ready = 1'b1;
      for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
         in_valid = (sent < 8);
         if (in_valid) begin
            a = $urandom; b = $urandom; cy_in = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         if (in_valid) begin
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready cyc=%0d got=%b exp=1", cyc, in_ready); end
            if (in_ready) begin q.push_back(model(a, b, cy_in, sub)); sent++; end
         end
         if (started) begin
            checks++;
            if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_gap cyc=%0d got=%b exp=1", cyc, out_valid); end
         end
         if (out_valid && out_ready) begin
            started = 1;
            exp = (q.size() > 0) ? q.pop_front() : res_t'('x);
            checks++;
            if (observed() !== exp) begin failures++; $display("FAIL b2b_result n=%0d got=%h exp=%h", got, observed(), exp); end
            got++;
            if (got == 8) started = 0;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      checks++;
      if (got !== 8 || q.size() !== 0) begin failures++; $display("FAIL b2b_count got=%0d left=%0d exp=8/0", got, q.size()); end
   endtask

   task automatic test_stall();
      localparam int N = 10;
      int   sent, got;
      bit   pending, held_prev;
      res_t held_val, exp;
      q.delete(); sent = 0; got = 0; pending = 0; held_prev = 0; held_val = '0;
      for (int cyc = 0; cyc < 300 && got < N; cyc++) begin
         if (!pending && sent < N) begin
            a = $urandom; b = $urandom; cy_in = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            pending = 1;
         end
         in_valid  = pending;
         out_ready = (cyc < 7) ? 1'b0 : 1'($urandom_range(0, 1));
         @(negedge clk);
         if (held_prev) begin
            checks++;
            if (out_valid !== 1'b1 || observed() !== held_val) begin
               failures++;
               $display("FAIL stall_hold cyc=%0d got=%b/%h exp=1/%h", cyc, out_valid, observed(), held_val);
            end
         end
         if (cyc < 7 && out_valid) begin
            checks++;
            if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", cyc, in_ready); end
         end
         held_prev = out_valid && !out_ready;
         held_val  = observed();
         if (in_valid && in_ready) begin q.push_back(model(a, b, cy_in, sub)); sent++; pending = 0; end
         if (out_valid && out_ready) begin
            exp = (q.size() > 0) ? q.pop_front() : res_t'('x);
            checks++;
            if (observed() !== exp) begin failures++; $display("FAIL stall_result n=%0d got=%h exp=%h", got, observed(), exp); end
            got++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++;
      if (got !== N || q.size() !== 0) begin failures++; $display("FAIL stall_count got=%0d left=%0d exp=%0d/0", got, q.size(), N); end
   endtask

   task automatic test_reset_mid();
      int   lat;
      res_t first, exp;
      q.delete(); out_ready = 1'b0;
      first = model(32'h1111_1111, 32'd0, 1'b0, ADD_OP);
      for (int i = 0; i < 4; i++) begin
         a = 32'h1111_1111 * (i + 1); b = i; cy_in = 1'b0; sub = ADD_OP; in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || observed() !== first) begin
         failures++; $display("FAIL rstmid_pre got=%b/%h exp=1/%h", out_valid, observed(), first);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
      checks++;
      if (observed() !== res_t'(0)) begin failures++; $display("FAIL rstmid_outputs got=%h exp=0", observed()); end
      @(posedge clk); @(posedge clk); #2 rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_stale cyc=%0d got=%b exp=0", i, out_valid); end
      end
      @(posedge clk); #1;
      a = 32'h1234_5678; b = 32'h9ABC_DEF0; cy_in = 1'b1; sub = SUB_OP; in_valid = 1'b1;
      exp = model(a, b, cy_in, sub);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      checks++;
      if (lat !== 4 || observed() !== exp) begin
         failures++; $display("FAIL rstmid_next lat=%0d got=%h exp=4/%h", lat, observed(), exp);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_small();
      int lat;
      a2 = 8'h80; b2 = 8'h80; cy2 = 1'b1; sub2 = ADD_OP; v2 = 1'b1; or2 = 1'b1;
      @(posedge clk); #1;
      v2 = 1'b0;
      lat = 1;
      while (!ov2 && lat < 20) begin @(posedge clk); #1; lat++; end
      checks++;
      if (lat !== 2) begin failures++; $display("FAIL w8_latency got=%0d exp=2", lat); end
      checks++;
      if ({s2, co2, z2, f2} !== {8'h01, 1'b1, 1'b0, 1'b1}) begin
         failures++; $display("FAIL w8_result got=%h exp=%h", {s2, co2, z2, f2}, {8'h01, 1'b1, 1'b0, 1'b1});
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_carry_wrap();
      test_sub_ovf();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      test_small();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
